// File: rtl/mutual_pkg.sv
// Shared definitions for the mutual-exclusion rule scheduler: node-state and
// rule-kind encodings, the scheduler FSM state type, the LFSR seed, and
// helpers that map (node, kind) to a rule index and evaluate a rule guard.
package mutual_pkg;

    localparam logic [1:0] ST_I = 2'd0;
    localparam logic [1:0] ST_T = 2'd1;
    localparam logic [1:0] ST_C = 2'd2;
    localparam logic [1:0] ST_E = 2'd3;

    localparam logic [1:0] RK_TRY  = 2'd0;
    localparam logic [1:0] RK_CRIT = 2'd1;
    localparam logic [1:0] RK_EXIT = 2'd2;
    localparam logic [1:0] RK_IDLE = 2'd3;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_EVAL     = 2'd1,
        S_ISSUE    = 2'd2,
        S_WAIT_UPD = 2'd3
    } sched_state_t;

    // Rule index layout: four consecutive rules per node.
    function automatic int rule_idx(input int node, input logic [1:0] kind);
        return node * 4 + int'(kind);
    endfunction

    // Guard of one rule given the owning node's state and the semaphore.
    function automatic logic rule_guard(input logic [1:0] nst, input logic [1:0] kind,
                                        input logic x);
        logic g;
        case (kind)
            RK_TRY:  g = (nst == ST_I);
            RK_CRIT: g = (nst == ST_T) && x;
            RK_EXIT: g = (nst == ST_C);
            RK_IDLE: g = (nst == ST_E);
            default: g = 1'b0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/mutual_rr_pick.sv
// Combinational circular priority pick: returns the first set request bit at
// or after ptr, wrapping past WIDTH-1 back to 0, plus an any-set flag.
// ptr is expected to be below WIDTH.
module mutual_rr_pick #(
    parameter int WIDTH = 12,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int sum;
    logic [IDX_W-1:0] cand;

    // Scan WIDTH candidates starting at ptr; the first request seen wins.
    always_comb begin
        idx  = '0;
        any  = 1'b0;
        sum  = 0;
        cand = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum  = int'(ptr) + i;
            cand = (sum >= WIDTH) ? IDX_W'(sum - WIDTH) : IDX_W'(sum);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end else begin
                idx = idx;
            end
        end
    end

endmodule

// File: rtl/mutual_rule_scheduler.sv
// Rule-enable command issuer for the mutual-exclusion `system` block.
// Reads node states and the semaphore, picks one enabled rule per step
// (round-robin from the last pick), issues it over valid/ready, counts
// firings up to a programmed limit and flags deadlock.
// Optional build macro MUTUAL_SCHED_LFSR_EN: the search start point comes
// from a free-running 16-bit LFSR instead of the round-robin pointer.
module mutual_rule_scheduler
    import mutual_pkg::*;
#(
    parameter  int NUM_NODES = 3,
    parameter  int STEP_W    = 16,
    localparam int NUM_RULES = 4 * NUM_NODES,
    localparam int RULE_W    = $clog2(NUM_RULES)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [STEP_W-1:0]      max_steps,
    input  logic [2*NUM_NODES-1:0] n_state,
    input  logic                   x_state,
    output logic                   en_valid,
    input  logic                   en_ready,
    output logic [RULE_W-1:0]      en_rule,
    output logic                   busy,
    output logic                   done,
    output logic                   deadlock,
    output logic [STEP_W-1:0]      step_count
);

    sched_state_t       state_r, state_nxt_s;
    logic [STEP_W-1:0]  limit_r, limit_nxt_s;
    logic [STEP_W-1:0]  step_count_r, step_count_nxt_s;
    logic [RULE_W-1:0]  rr_ptr_r, rr_ptr_nxt_s;
    logic [RULE_W-1:0]  en_rule_r, en_rule_nxt_s;
    logic               en_valid_r, en_valid_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               done_r, done_nxt_s;
    logic               deadlock_r, deadlock_nxt_s;
    logic [NUM_RULES-1:0] en_vec_s;
    logic [RULE_W-1:0]  search_ptr_s;
    logic [RULE_W-1:0]  pick_idx_s;
    logic               pick_any_s;

`ifdef MUTUAL_SCHED_LFSR_EN
    logic [15:0] lfsr_r;

    // Fibonacci LFSR, taps 16,14,13,11, stepping every cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
        end
    end

    assign search_ptr_s = RULE_W'(int'(lfsr_r[RULE_W-1:0]) % NUM_RULES);
`else
    assign search_ptr_s = rr_ptr_r;
`endif

    // Guard of every rule from the live protocol state.
    always_comb begin
        en_vec_s = '0;
        for (int i = 0; i < NUM_NODES; i++) begin
            for (int k = 0; k < 4; k++) begin
                en_vec_s[rule_idx(i, 2'(k))] = rule_guard(n_state[2*i +: 2], 2'(k), x_state);
            end
        end
    end

    mutual_rr_pick #(
        .WIDTH (NUM_RULES),
        .IDX_W (RULE_W)
    ) u_pick (
        .req (en_vec_s),
        .ptr (search_ptr_s),
        .idx (pick_idx_s),
        .any (pick_any_s)
    );

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start && (max_steps != '0)) state_nxt_s = S_EVAL;
                else                            state_nxt_s = S_IDLE;
            end
            S_EVAL: begin
                if (pick_any_s) state_nxt_s = S_ISSUE;
                else            state_nxt_s = S_IDLE;
            end
            S_ISSUE: begin
                if (en_ready) state_nxt_s = S_WAIT_UPD;
                else          state_nxt_s = S_ISSUE;
            end
            S_WAIT_UPD: begin
                if (step_count_r >= limit_r) state_nxt_s = S_IDLE;
                else                         state_nxt_s = S_EVAL;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and run bookkeeping.
    always_comb begin
        limit_nxt_s      = limit_r;
        step_count_nxt_s = step_count_r;
        rr_ptr_nxt_s     = rr_ptr_r;
        en_rule_nxt_s    = en_rule_r;
        en_valid_nxt_s   = en_valid_r;
        busy_nxt_s       = busy_r;
        done_nxt_s       = 1'b0;
        deadlock_nxt_s   = deadlock_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    limit_nxt_s      = max_steps;
                    step_count_nxt_s = '0;
                    deadlock_nxt_s   = 1'b0;
                    if (max_steps == '0) begin
                        done_nxt_s = 1'b1;
                        busy_nxt_s = 1'b0;
                    end else begin
                        busy_nxt_s = 1'b1;
                    end
                end else begin
                    busy_nxt_s = busy_r;
                end
            end
            S_EVAL: begin
                if (pick_any_s) begin
                    en_rule_nxt_s  = pick_idx_s;
                    en_valid_nxt_s = 1'b1;
                end else begin
                    deadlock_nxt_s = 1'b1;
                    done_nxt_s     = 1'b1;
                    busy_nxt_s     = 1'b0;
                end
            end
            S_ISSUE: begin
                if (en_ready) begin
                    en_valid_nxt_s   = 1'b0;
                    step_count_nxt_s = (step_count_r < limit_r) ?
                                       step_count_r + STEP_W'(1) : step_count_r;
                    rr_ptr_nxt_s     = (en_rule_r == RULE_W'(NUM_RULES - 1)) ?
                                       '0 : en_rule_r + RULE_W'(1);
                end else begin
                    en_valid_nxt_s = 1'b1;
                end
            end
            S_WAIT_UPD: begin
                if (step_count_r >= limit_r) begin
                    done_nxt_s = 1'b1;
                    busy_nxt_s = 1'b0;
                end else begin
                    busy_nxt_s = 1'b1;
                end
            end
            default: begin
                en_valid_nxt_s = 1'b0;
                busy_nxt_s     = 1'b0;
            end
        endcase
    end

    // Output and bookkeeping registers; reset drops everything with no done.
    always_ff @(posedge clock) begin
        if (!reset) begin
            limit_r      <= '0;
            step_count_r <= '0;
            rr_ptr_r     <= '0;
            en_rule_r    <= '0;
            en_valid_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            deadlock_r   <= 1'b0;
        end else begin
            limit_r      <= limit_nxt_s;
            step_count_r <= step_count_nxt_s;
            rr_ptr_r     <= rr_ptr_nxt_s;
            en_rule_r    <= en_rule_nxt_s;
            en_valid_r   <= en_valid_nxt_s;
            busy_r       <= busy_nxt_s;
            done_r       <= done_nxt_s;
            deadlock_r   <= deadlock_nxt_s;
        end
    end

    assign en_valid   = en_valid_r;
    assign en_rule    = en_rule_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign deadlock   = deadlock_r;
    assign step_count = step_count_r;

endmodule

// File: tb/tb_mutual_rule_scheduler.sv
// Self-checking bench for mutual_rule_scheduler with a behavioural model of
// the `system` block and a queue of expected rule picks.
module tb_mutual_rule_scheduler;

    localparam int NUM_NODES = 3;
    localparam int STEP_W    = 16;
    localparam int NUM_RULES = 12;
    localparam int RULE_W    = 4;

    logic                   clock = 1'b0;
    logic                   reset = 1'b0;
    logic                   start = 1'b0;
    logic [STEP_W-1:0]      max_steps = '0;
    logic [2*NUM_NODES-1:0] n_state = '0;
    logic                   x_state = 1'b1;
    logic                   en_ready = 1'b0;
    logic                   en_valid;
    logic [RULE_W-1:0]      en_rule;
    logic                   busy;
    logic                   done;
    logic                   deadlock;
    logic [STEP_W-1:0]      step_count;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    mutual_rule_scheduler #(.NUM_NODES(NUM_NODES), .STEP_W(STEP_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .max_steps  (max_steps),
        .n_state    (n_state),
        .x_state    (x_state),
        .en_valid   (en_valid),
        .en_ready   (en_ready),
        .en_rule    (en_rule),
        .busy       (busy),
        .done       (done),
        .deadlock   (deadlock),
        .step_count (step_count)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Guard of rule r from the bench's view of the protocol state.
    function automatic int model_guard(input logic [5:0] ns, input logic x, input int r);
        logic [1:0] nst;
        nst = ns[2*(r/4) +: 2];
        case (r % 4)
            0: return int'(nst == 2'd0);
            1: return int'((nst == 2'd1) && x);
            2: return int'(nst == 2'd2);
            3: return int'(nst == 2'd3);
            default: return 0;
        endcase
    endfunction

    // Behavioural `system`: apply the fired rule to node and semaphore.
    task automatic model_apply(input int r);
        int node;
        node = r / 4;
        case (r % 4)
            0: n_state[2*node +: 2] = 2'd1;
            1: begin n_state[2*node +: 2] = 2'd2; x_state = 1'b0; end
            2: begin n_state[2*node +: 2] = 2'd3; x_state = 1'b1; end
            3: n_state[2*node +: 2] = 2'd0;
            default: n_state = n_state;
        endcase
    endtask

    // Start a run and follow it to done, scoring each handshake.
    task automatic run_scored(input int steps, input int budget, input bit model_on,
                              input bit use_sb, output int fired, output int first_pick);
        bit done_seen;
        bit hs;
        int r;
        fired      = 0;
        first_pick = -1;
        done_seen  = 1'b0;
        max_steps  = STEP_W'(steps);
        start      = 1'b1;
        tick();
        start      = 1'b0;
        for (int c = 0; c < budget && !done_seen; c++) begin
            hs = en_valid && en_ready;
            r  = int'(en_rule);
            if (hs) begin
                fired++;
                if (first_pick < 0) first_pick = r;
                check_eq("guard_at_issue", model_guard(n_state, x_state, r), 1);
                if (use_sb) begin
                    if (exp_q.size() > 0) check_eq("pick", r, exp_q.pop_front());
                    else                  check_eq("sb_underflow", exp_q.size(), 1);
                end
            end
            tick();
            if (hs && model_on) model_apply(r);
            if (done) done_seen = 1'b1;
        end
        if (!done_seen) check_eq("run_timeout", 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fired;
        int fp;
        int node_seen;
        int distinct;

        // Reset state
        reset = 1'b0;
        tick();
        tick();
        check_eq("rst_en_valid", en_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_deadlock", deadlock, 0);
        check_eq("rst_step_count", step_count, 0);
        check_eq("rst_en_rule", en_rule, 0);
        reset = 1'b1;
        tick();

`ifndef MUTUAL_SCHED_LFSR_EN
        // Held-off ready: rule 0 stays stable, done two cycles after handshake
        n_state = '0; x_state = 1'b1; en_ready = 1'b0; max_steps = 16'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("t1_busy", busy, 1);
        check_eq("t1_valid_early", en_valid, 0);
        tick();
        check_eq("t1_valid_lat2", en_valid, 1);
        check_eq("t1_rule", en_rule, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("t1_valid_hold", en_valid, 1);
            check_eq("t1_rule_hold", en_rule, 0);
        end
        en_ready = 1'b1;
        tick();
        en_ready = 1'b0;
        check_eq("t1_valid_drop", en_valid, 0);
        check_eq("t1_step_count", step_count, 1);
        check_eq("t1_done_early", done, 0);
        tick();
        check_eq("t1_done", done, 1);
        check_eq("t1_busy_end", busy, 0);
        tick();
        check_eq("t1_done_pulse", done, 0);

        // Pointer advanced past rule 0: same state now picks rule 4
        en_ready = 1'b1;
        exp_q.push_back(4);
        run_scored(1, 20, 1'b0, 1'b1, fired, fp);
        check_eq("t1b_fired", fired, 1);

        // Full protocol run with ready held high
        reset = 1'b0; tick(); reset = 1'b1;
        n_state = '0; x_state = 1'b1; en_ready = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(i);
        run_scored(8, 200, 1'b1, 1'b1, fired, fp);
        check_eq("t2_fired", fired, 8);
        check_eq("t2_step_count", step_count, 8);
        check_eq("t2_busy_end", busy, 0);
        check_eq("t2_sb_left", exp_q.size(), 0);
`endif

        // Deadlock: all nodes trying, semaphore taken
        en_ready = 1'b1; n_state = 6'b010101; x_state = 1'b0; max_steps = 16'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("t3_busy", busy, 1);
        check_eq("t3_valid0", en_valid, 0);
        tick();
        check_eq("t3_done", done, 1);
        check_eq("t3_deadlock", deadlock, 1);
        check_eq("t3_busy_end", busy, 0);
        check_eq("t3_valid1", en_valid, 0);
        tick();
        check_eq("t3_done_pulse", done, 0);
        check_eq("t3_deadlock_sticky", deadlock, 1);

        // Zero-step run
        n_state = '0; x_state = 1'b1; max_steps = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("t4_done", done, 1);
        check_eq("t4_busy", busy, 0);
        check_eq("t4_valid", en_valid, 0);
        check_eq("t4_deadlock_clr", deadlock, 0);
        tick();
        check_eq("t4_done_pulse", done, 0);
        check_eq("t4_valid1", en_valid, 0);

        // Reset in the middle of ISSUE
        n_state = '0; x_state = 1'b1; en_ready = 1'b0; max_steps = 16'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_eq("t5_in_issue", en_valid, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_eq("t5_valid", en_valid, 0);
        check_eq("t5_busy", busy, 0);
        check_eq("t5_step_count", step_count, 0);
        check_eq("t5_done", done, 0);
        tick();
        check_eq("t5_done_after", done, 0);
        check_eq("t5_valid_after", en_valid, 0);
        en_ready = 1'b1;
`ifndef MUTUAL_SCHED_LFSR_EN
        exp_q.push_back(0);
        run_scored(1, 30, 1'b0, 1'b1, fired, fp);
`else
        run_scored(1, 30, 1'b0, 1'b0, fired, fp);
`endif
        check_eq("t5_rerun_fired", fired, 1);
        check_eq("t5_rerun_steps", step_count, 1);

`ifdef MUTUAL_SCHED_LFSR_EN
        // Randomised start point: guards hold and picks spread over nodes
        node_seen = 0;
        for (int k = 0; k < 8; k++) begin
            n_state = '0; x_state = 1'b1;
            run_scored(1, 30, 1'b0, 1'b0, fired, fp);
            if (fp >= 0) node_seen = node_seen | (1 << (fp / 4));
            repeat (k + 1) tick();
        end
        distinct = $countones(node_seen);
        check_eq("t6_distinct_nodes", int'(distinct >= 2), 1);
        n_state = '0; x_state = 1'b1;
        run_scored(20, 600, 1'b1, 1'b0, fired, fp);
        check_eq("t6_fired", fired, 20);
        check_eq("t6_step_count", step_count, 20);
`else
        node_seen = 0;
        distinct  = 0;
`endif

        en_ready = 1'b0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
